// File: rtl/vip_rgb888_raw8_mosaic_if.sv
// Video bus between an RGB888 source and the RAW8 mosaic stage.
// The source drives per_*; the mosaic stage drives post_*.
interface vip_rgb888_raw8_mosaic_if;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_hsync;
  logic [7:0] per_img_red;
  logic [7:0] per_img_green;
  logic [7:0] per_img_blue;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_hsync;
  logic [7:0] post_img_RAW;

  modport master (
    output per_frame_vsync,
    output per_frame_href,
    output per_frame_hsync,
    output per_img_red,
    output per_img_green,
    output per_img_blue,
    input  post_frame_vsync,
    input  post_frame_href,
    input  post_frame_hsync,
    input  post_img_RAW
  );

  modport slave (
    input  per_frame_vsync,
    input  per_frame_href,
    input  per_frame_hsync,
    input  per_img_red,
    input  per_img_green,
    input  per_img_blue,
    output post_frame_vsync,
    output post_frame_href,
    output post_frame_hsync,
    output post_img_RAW
  );
endinterface

// File: rtl/vip_rgb888_raw8_mosaic.sv
// RGB888 -> Bayer RAW8 re-mosaic, 2-cycle latency, with geometry checks.
// Optional test pattern path enabled by defining MOSAIC_TPG_EN.
module vip_rgb888_raw8_mosaic #(
  parameter int         IMG_HDISP       = 1280,
  parameter int         IMG_VDISP       = 720,
  parameter logic [1:0] BAYER           = 2'd0,
  parameter bit         SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mirror,
`ifdef MOSAIC_TPG_EN
  input  logic       tpg_en,
`endif
  vip_rgb888_raw8_mosaic_if.slave vif,
  output logic       frame_start,
  output logic       line_len_err,
  output logic       frame_len_err
);

  localparam logic        DEAS     = SYNC_ACTIVE_LOW;
  localparam logic [13:0] HLEN     = 14'(IMG_HDISP);
  localparam logic [11:0] VLEN     = 12'(IMG_VDISP);
  localparam logic [13:0] PIX_MAX  = '1;
  localparam logic [11:0] LINE_MAX = '1;

  logic        vs_act_q, vs_act_d;
  logic        href_q, href_d;
  logic [13:0] pix_cnt_q, pix_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [1:0]  mir_q, mir_d;
  logic        seen_q, seen_d;
  logic        fs_q, fs_d;
  logic        lle_q, lle_d;
  logic        fle_q, fle_d;

  logic        s1_vs_q, s1_hr_q, s1_hs_q;
  logic [7:0]  s1_r_q, s1_g_q, s1_b_q;
  logic        s1_rp_q, s1_cp_q;
  logic        s1_rp_d, s1_cp_d;
  logic        s1_tpg_q, s1_tpg_d;
  logic        s2_vs_q, s2_hr_q, s2_hs_q;
  logic [7:0]  s2_raw_q, s2_raw_d;

  logic        vs_fall;
  logic        h_rise;
  logic        h_fall;
  logic [13:0] col;
  logic [7:0]  pick;

`ifdef MOSAIC_TPG_EN
  assign s1_tpg_d = tpg_en;
`else
  assign s1_tpg_d = 1'b0;
`endif

  always_comb begin
    vs_act_d   = vif.per_frame_vsync ^ DEAS;
    href_d     = vif.per_frame_href;
    vs_fall    = vs_act_q & ~vs_act_d;
    h_rise     = href_d & ~href_q;
    h_fall     = ~href_d & href_q;
    col        = h_rise ? 14'd0 : pix_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    lle_d      = lle_q;
    mir_d      = mir_q;
    seen_d     = seen_q;
    fle_d      = fle_q;
    fs_d       = vs_fall;
    if (href_d) begin
      pix_cnt_d = (col == PIX_MAX) ? col : col + 14'd1;
    end
    if (h_fall) begin
      if (line_cnt_q != LINE_MAX) begin
        line_cnt_d = line_cnt_q + 12'd1;
      end
      if (pix_cnt_q != HLEN) begin
        lle_d = 1'b1;
      end
    end
    // Frame-start clears take priority over the line bookkeeping above
    if (vs_fall) begin
      mir_d      = mirror;
      line_cnt_d = '0;
      lle_d      = 1'b0;
      seen_d     = 1'b1;
      fle_d      = seen_q & (line_cnt_q != VLEN);
    end
    s1_rp_d = line_cnt_q[0] ^ mir_q[1] ^ BAYER[1];
    s1_cp_d = col[0] ^ mir_q[0] ^ BAYER[0];
  end

  always_comb begin
    pick = s1_g_q;
    if (s1_tpg_q) begin
      unique case (1'b1)
        (~s1_rp_q & ~s1_cp_q): pick = 8'd200;
        (~s1_rp_q &  s1_cp_q): pick = 8'd150;
        ( s1_rp_q & ~s1_cp_q): pick = 8'd100;
        ( s1_rp_q &  s1_cp_q): pick = 8'd50;
      endcase
    end else begin
      unique case (1'b1)
        (~s1_rp_q & ~s1_cp_q): pick = s1_r_q;
        ( s1_rp_q &  s1_cp_q): pick = s1_b_q;
        (s1_rp_q ^ s1_cp_q):   pick = s1_g_q;
      endcase
    end
    s2_raw_d = s1_hr_q ? pick : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_q   <= 1'b0;
      href_q     <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      mir_q      <= 2'b00;
      seen_q     <= 1'b0;
      fs_q       <= 1'b0;
      lle_q      <= 1'b0;
      fle_q      <= 1'b0;
      s1_vs_q    <= DEAS;
      s1_hr_q    <= 1'b0;
      s1_hs_q    <= DEAS;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_rp_q    <= 1'b0;
      s1_cp_q    <= 1'b0;
      s1_tpg_q   <= 1'b0;
      s2_vs_q    <= DEAS;
      s2_hr_q    <= 1'b0;
      s2_hs_q    <= DEAS;
      s2_raw_q   <= '0;
    end else begin
      vs_act_q   <= vs_act_d;
      href_q     <= href_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      mir_q      <= mir_d;
      seen_q     <= seen_d;
      fs_q       <= fs_d;
      lle_q      <= lle_d;
      fle_q      <= fle_d;
      s1_vs_q    <= vif.per_frame_vsync;
      s1_hr_q    <= vif.per_frame_href;
      s1_hs_q    <= vif.per_frame_hsync;
      s1_r_q     <= vif.per_img_red;
      s1_g_q     <= vif.per_img_green;
      s1_b_q     <= vif.per_img_blue;
      s1_rp_q    <= s1_rp_d;
      s1_cp_q    <= s1_cp_d;
      s1_tpg_q   <= s1_tpg_d;
      s2_vs_q    <= s1_vs_q;
      s2_hr_q    <= s1_hr_q;
      s2_hs_q    <= s1_hs_q;
      s2_raw_q   <= s2_raw_d;
    end
  end

  assign vif.post_frame_vsync = s2_vs_q;
  assign vif.post_frame_href  = s2_hr_q;
  assign vif.post_frame_hsync = s2_hs_q;
  assign vif.post_img_RAW     = s2_raw_q;
  assign frame_start          = fs_q;
  assign line_len_err         = lle_q;
  assign frame_len_err        = fle_q;

endmodule
